stack_reg_file: RTL and testbench
=================================

// Module: stack_reg_file
// PURPOSE
//  Parametrised general-purpose register file with a built-in hardware stack pointer.
//  The top register (index NUM_REGS-1) is the SP. It is auto-incremented and decremented by pop and push strobes.
//  Range limits on the SP raise sticky overflow/underflow flags.
//  Sits in the datapath between decode (addresses, strobes) and the ALU/memory stage (operands, SP address).
//  Two async-read ports, one sync write port, optional write-to-read bypass, optional hardwired-zero R0.
// PARAMETERS
//  DATA_W    8      register width in bits
//  NUM_REGS  4      register count (>=2); SP is R[NUM_REGS-1]; ADDR_W = max(1,$clog2(NUM_REGS)) (localparam)
//  SP_RESET  {DATA_W{1'b1}}  SP value after reset
//  SP_MIN    0      lowest legal SP; a push at SP==SP_MIN overflows
//  SP_MAX    {DATA_W{1'b1}}  highest legal SP; a pop at SP==SP_MAX underflows
//  BYPASS    1      1: read port returns write_data when write_en && read_addr==write_addr
//  ZERO_R0   0      1: R0 reads 0, writes to R0 ignored
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  write_en     in   1       write strobe
//  write_addr   in   ADDR_W  write register index
//  write_data   in   DATA_W  write value
//  read_addr_a  in   ADDR_W  port A index
//  read_addr_b  in   ADDR_W  port B index
//  stack_push   in   1       decrement SP this cycle
//  stack_pop    in   1       increment SP this cycle
//  err_clr      in   1       clear sticky error flags
//  read_data_a  out  DATA_W  port A data (combinational)
//  read_data_b  out  DATA_W  port B data (combinational)
//  sp_value     out  DATA_W  current registered SP (no bypass)
//  sp_ovf       out  1       sticky: push attempted at SP_MIN
//  sp_udf       out  1       sticky: pop attempted at SP_MAX
// BEHAVIOUR
//  Reset (rst_n low, async): R[0..NUM_REGS-2]=0, SP=SP_RESET, sp_ovf=sp_udf=0; held while low.
//  Write: on posedge, if write_en, R[write_addr]<=write_data; 1-cycle latency to registered value.
//  Address >= NUM_REGS: write ignored, read returns 0. Write to R0 with ZERO_R0=1 is ignored.
//  Reads: pure combinational from the array. BYPASS=1 and write_en and read_addr==write_addr (legal, non-zero-R0):
//    return write_data same cycle. Bypass never applies to sp_value.
//  SP update priority per posedge, evaluated in this order:
//   1) write_en && write_addr==SP: SP<=write_data; push/pop ignored, no flags.
//   2) push && pop: SP unchanged, no flags.
//   3) push only: SP!=SP_MIN -> SP<=SP-1; else SP unchanged, sp_ovf<=1.
//   4) pop only:  SP!=SP_MAX -> SP<=SP+1; else SP unchanged, sp_udf<=1.
//  SP arithmetic is DATA_W-bit. SP never wraps; limits are checked before the update.
//  Flags: err_clr clears both on posedge. A new error in the same cycle wins (flag stays/becomes 1).
//  Writes to a non-SP register and push/pop in the same cycle both take effect.
//  Reset mid-operation: all state is forced to reset values immediately; pending strobes are lost.
// TESTING
//  1 Reset: drop rst_n mid-cycle after writes -> R0..R2=0x00, sp_value=0xFF, flags 0, async (before next edge).
//  2 Write/read: write R1=0xA5, then read A=R1, B=R2 -> 0xA5/0x00; with BYPASS=1, same-cycle read of R1 -> 0xA5.
//  3 Stack: 3 pushes from 0xFF -> sp_value 0xFC; 2 pops -> 0xFE; push+pop together -> stays 0xFE.
//  4 Limits: SP=0x00 + push -> SP 0x00, sp_ovf=1; SP=0xFF + pop -> SP 0xFF, sp_udf=1.
//    err_clr+push at 0x00 -> sp_ovf stays 1; err_clr alone -> 0.
//  5 Collision: write_en to R3=0x40 with stack_push -> SP=0x40, no flag; write R2=0x11 with push -> both occur.
//  6 Params: NUM_REGS=6, DATA_W=16, ZERO_R0=1 -> R0 write ignored/reads 0; addr 7 reads 0; SP=R5 reset 0xFFFF.

Source files
------------

// File: rtl/stack_reg_file.sv
// Register file whose top register is a hardware stack pointer with sticky range flags.
// Reads are combinational, writes and SP updates take one cycle; strobes are always accepted.
module stack_reg_file #(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 4,
    parameter logic [DATA_W-1:0] SP_RESET = '1,
    parameter logic [DATA_W-1:0] SP_MIN   = '0,
    parameter logic [DATA_W-1:0] SP_MAX   = '1,
    parameter int                BYPASS   = 1,
    parameter int                ZERO_R0  = 0,
    localparam int               ADDR_W   = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    input  logic              stack_push,
    input  logic              stack_pop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b,
    output logic [DATA_W-1:0] sp_value,
    output logic              sp_ovf,
    output logic              sp_udf
);

    localparam logic [ADDR_W-1:0] SP_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NREGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS-1];
    logic [DATA_W-1:0] r_sp;
    logic              r_ovf;
    logic              r_udf;

    logic              w_wr_legal;
    logic              w_sp_wr;
    logic              w_push_only;
    logic              w_pop_only;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // A legal write targets an existing register that is not a hardwired-zero R0.
    assign w_wr_legal  = write_en && ({1'b0, write_addr} < NREGS_W)
                         && !((ZERO_R0 != 0) && (write_addr == '0));
    assign w_sp_wr     = write_en && (write_addr == SP_IDX);
    assign w_push_only = stack_push && !stack_pop && !w_sp_wr;
    assign w_pop_only  = stack_pop && !stack_push && !w_sp_wr;
    assign w_ovf_set   = w_push_only && (r_sp == SP_MIN);
    assign w_udf_set   = w_pop_only && (r_sp == SP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_legal) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (write_addr == ADDR_W'(i)) begin
                    r_regs[i] <= write_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= SP_RESET;
        end else if (w_sp_wr) begin
            r_sp <= write_data;
        end else if (w_push_only && !w_ovf_set) begin
            r_sp <= r_sp - 1'b1;
        end else if (w_pop_only && !w_udf_set) begin
            r_sp <= r_sp + 1'b1;
        end
    end

    // A fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set || (r_ovf && !err_clr);
            r_udf <= w_udf_set || (r_udf && !err_clr);
        end
    end

    always_comb begin
        w_rd_a = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (read_addr_a == ADDR_W'(i)) begin
                w_rd_a = r_regs[i];
            end
        end
        if (read_addr_a == SP_IDX) begin
            w_rd_a = r_sp;
        end
        if ((ZERO_R0 != 0) && (read_addr_a == '0)) begin
            w_rd_a = '0;
        end
        if ((BYPASS != 0) && w_wr_legal && (read_addr_a == write_addr)) begin
            w_rd_a = write_data;
        end
    end

    always_comb begin
        w_rd_b = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (read_addr_b == ADDR_W'(i)) begin
                w_rd_b = r_regs[i];
            end
        end
        if (read_addr_b == SP_IDX) begin
            w_rd_b = r_sp;
        end
        if ((ZERO_R0 != 0) && (read_addr_b == '0)) begin
            w_rd_b = '0;
        end
        if ((BYPASS != 0) && w_wr_legal && (read_addr_b == write_addr)) begin
            w_rd_b = write_data;
        end
    end

    assign read_data_a = w_rd_a;
    assign read_data_b = w_rd_b;
    assign sp_value    = r_sp;
    assign sp_ovf      = r_ovf;
    assign sp_udf      = r_udf;

endmodule

// File: tb/tb_stack_reg_file.sv
// Bench for stack_reg_file: default 8-bit/4-reg instance plus a 16-bit/6-reg zero-R0 instance,
// both compared each cycle against an array/integer reference model through an expectation queue.
module tb_stack_reg_file;

    localparam int NR   [2] = '{4, 6};
    localparam int MASK [2] = '{255, 65535};
    localparam bit Z0   [2] = '{1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic in_we   [2];
    int   in_wa   [2];
    int   in_wd   [2];
    int   in_ra   [2];
    int   in_rb   [2];
    logic in_push [2];
    logic in_pop  [2];
    logic in_clr  [2];

    logic [1:0]  wa0, ra0, rb0;
    logic [7:0]  wd0, rda0, rdb0, sp0;
    logic        ovf0, udf0;
    logic [2:0]  wa1, ra1, rb1;
    logic [15:0] wd1, rda1, rdb1, sp1;
    logic        ovf1, udf1;

    assign wa0 = in_wa[0][1:0];
    assign ra0 = in_ra[0][1:0];
    assign rb0 = in_rb[0][1:0];
    assign wd0 = in_wd[0][7:0];
    assign wa1 = in_wa[1][2:0];
    assign ra1 = in_ra[1][2:0];
    assign rb1 = in_rb[1][2:0];
    assign wd1 = in_wd[1][15:0];

    stack_reg_file u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .write_en(in_we[0]), .write_addr(wa0), .write_data(wd0),
        .read_addr_a(ra0), .read_addr_b(rb0),
        .stack_push(in_push[0]), .stack_pop(in_pop[0]), .err_clr(in_clr[0]),
        .read_data_a(rda0), .read_data_b(rdb0), .sp_value(sp0),
        .sp_ovf(ovf0), .sp_udf(udf0)
    );

    stack_reg_file #(.DATA_W(16), .NUM_REGS(6), .ZERO_R0(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .write_en(in_we[1]), .write_addr(wa1), .write_data(wd1),
        .read_addr_a(ra1), .read_addr_b(rb1),
        .stack_push(in_push[1]), .stack_pop(in_pop[1]), .err_clr(in_clr[1]),
        .read_data_a(rda1), .read_data_b(rdb1), .sp_value(sp1),
        .sp_ovf(ovf1), .sp_udf(udf1)
    );

    // Reference model: plain register array, SP as an integer, two flags.
    int m_regs [2][8];
    int m_sp   [2];
    bit m_ovf  [2];
    bit m_udf  [2];

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 8; a++) m_regs[d][a] = 0;
            m_sp[d]  = MASK[d];
            m_ovf[d] = 1'b0;
            m_udf[d] = 1'b0;
        end
    endtask

    function automatic int m_read(int d, int a);
        if (a >= NR[d]) return 0;
        if (Z0[d] && a == 0) return 0;
        if (in_we[d] && in_wa[d] == a) return in_wd[d];
        if (a == NR[d] - 1) return m_sp[d];
        return m_regs[d][a];
    endfunction

    task automatic m_clock(int d);
        int spi;
        bit new_ovf;
        bit new_udf;
        spi     = NR[d] - 1;
        new_ovf = 1'b0;
        new_udf = 1'b0;
        if (in_we[d] && in_wa[d] < spi && !(Z0[d] && in_wa[d] == 0))
            m_regs[d][in_wa[d]] = in_wd[d];
        if (in_we[d] && in_wa[d] == spi) begin
            m_sp[d] = in_wd[d];
        end else if (in_push[d] && in_pop[d]) begin
            m_sp[d] = m_sp[d];
        end else if (in_push[d]) begin
            if (m_sp[d] == 0) new_ovf = 1'b1;
            else m_sp[d] = m_sp[d] - 1;
        end else if (in_pop[d]) begin
            if (m_sp[d] == MASK[d]) new_udf = 1'b1;
            else m_sp[d] = m_sp[d] + 1;
        end
        m_ovf[d] = new_ovf || (m_ovf[d] && !in_clr[d]);
        m_udf[d] = new_udf || (m_udf[d] && !in_clr[d]);
    endtask

    typedef struct {
        int    d;
        int    rda;
        int    rdb;
        int    sp;
        bit    ovf;
        bit    udf;
        string tag;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_now(string tag);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e.d   = d;
            e.rda = m_read(d, in_ra[d]);
            e.rdb = m_read(d, in_rb[d]);
            e.sp  = m_sp[d];
            e.ovf = m_ovf[d];
            e.udf = m_udf[d];
            e.tag = tag;
            q.push_back(e);
        end
    endtask

    task automatic cmp(string tag, int d, string what, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d %s actual=0x%0h required=0x%0h", tag, d, what, act, req);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.d == 0) begin
                    cmp(e.tag, 0, "read_a", {24'b0, rda0}, e.rda);
                    cmp(e.tag, 0, "read_b", {24'b0, rdb0}, e.rdb);
                    cmp(e.tag, 0, "sp",     {24'b0, sp0},  e.sp);
                    cmp(e.tag, 0, "ovf",    {31'b0, ovf0}, {31'b0, e.ovf});
                    cmp(e.tag, 0, "udf",    {31'b0, udf0}, {31'b0, e.udf});
                end else begin
                    cmp(e.tag, 1, "read_a", {16'b0, rda1}, e.rda);
                    cmp(e.tag, 1, "read_b", {16'b0, rdb1}, e.rdb);
                    cmp(e.tag, 1, "sp",     {16'b0, sp1},  e.sp);
                    cmp(e.tag, 1, "ovf",    {31'b0, ovf1}, {31'b0, e.ovf});
                    cmp(e.tag, 1, "udf",    {31'b0, udf1}, {31'b0, e.udf});
                end
            end
        end
    end

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            in_we[d] = 1'b0; in_wa[d] = 0; in_wd[d] = 0;
            in_ra[d] = 0;    in_rb[d] = 0;
            in_push[d] = 1'b0; in_pop[d] = 1'b0; in_clr[d] = 1'b0;
        end
    endtask

    task automatic wr(int d, int a, int v);
        in_we[d] = 1'b1; in_wa[d] = a; in_wd[d] = v;
    endtask

    // Inputs are set just after a rising edge; expectations queued here are checked at the next falling edge.
    task automatic tick(string tag);
        expect_now(tag);
        @(posedge clk);
        if (rst_n) begin
            m_clock(0);
            m_clock(1);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        m_reset();
        @(posedge clk);
        #1;
        tick("reset_hold");
        rst_n = 1'b1;
        tick("reset_release");

        wr(0, 1, 8'h5A); wr(1, 1, 16'h1234); tick("pre_wr1");
        wr(0, 2, 8'h33); tick("pre_wr2");
        idle(); in_ra[0] = 1; in_rb[0] = 2; in_push[0] = 1'b1; in_pop[1] = 1'b1;
        tick("pre_push");
        idle(); in_ra[0] = 1; in_rb[0] = 3; in_ra[1] = 1; in_rb[1] = 5;
        #1;
        rst_n = 1'b0;
        m_reset();
        expect_now("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("after_rst");

        idle(); wr(0, 1, 8'hA5); in_ra[0] = 1; in_rb[0] = 2;
        wr(1, 0, 16'hBEEF); in_ra[1] = 0; in_rb[1] = 7;
        tick("bypass_r1");
        idle(); in_ra[0] = 1; in_rb[0] = 2; in_ra[1] = 0; in_rb[1] = 5;
        tick("read_r1");
        in_ra[1] = 6; in_rb[1] = 7; wr(1, 7, 16'h5555);
        tick("illegal_addr");

        idle(); in_push[0] = 1'b1; in_push[1] = 1'b1; in_rb[0] = 3; in_rb[1] = 5;
        repeat (3) tick("push");
        in_push[0] = 1'b0; in_pop[0] = 1'b1;
        repeat (2) tick("pop");
        in_push[0] = 1'b1;
        tick("push_pop");
        idle();
        tick("after_push_pop");

        wr(0, 3, 0); tick("sp_to_min");
        idle(); in_push[0] = 1'b1; tick("push_at_min");
        idle(); tick("ovf_set");
        in_clr[0] = 1'b1; in_push[0] = 1'b1; tick("clr_with_push_min");
        idle(); tick("ovf_held");
        in_clr[0] = 1'b1; tick("clr_alone");
        idle(); tick("ovf_cleared");
        wr(0, 3, 8'hFF); wr(1, 5, 16'hFFFF); tick("sp_to_max");
        idle(); in_pop[0] = 1'b1; in_pop[1] = 1'b1; tick("pop_at_max");
        idle(); tick("udf_set");
        in_clr[0] = 1'b1; in_clr[1] = 1'b1; tick("udf_clr");
        idle(); tick("udf_cleared");

        wr(0, 3, 8'h40); in_push[0] = 1'b1; tick("wr_sp_with_push");
        idle(); tick("sp_40");
        wr(0, 2, 8'h11); in_push[0] = 1'b1; in_ra[0] = 2; tick("wr_r2_with_push");
        idle(); in_ra[0] = 2; in_rb[0] = 3; tick("both_applied");

        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                in_we[d] = ($urandom % 3) == 0;
                in_wa[d] = $urandom_range(0, (d == 0) ? 3 : 7);
                case ($urandom % 4)
                    0:       in_wd[d] = 0;
                    1:       in_wd[d] = MASK[d];
                    2:       in_wd[d] = (($urandom % 2) == 0) ? 1 : MASK[d] - 1;
                    default: in_wd[d] = int'($urandom) & MASK[d];
                endcase
                in_ra[d]   = $urandom_range(0, (d == 0) ? 3 : 7);
                in_rb[d]   = $urandom_range(0, (d == 0) ? 3 : 7);
                in_push[d] = ($urandom % 3) == 0;
                in_pop[d]  = ($urandom % 3) == 0;
                in_clr[d]  = ($urandom % 8) == 0;
            end
            tick("rand");
        end

        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
